hazard_ctrl: RTL and testbench

// - Sequences the EX stage: generates registered forwarding selects, load-use stalls and branch/jump flushes.
// - Sits beside ID/EX and EX/MEM. Drives ALU FwdRs/FwdRt/Flush, PC_Stall and IfId_Stall.
// - Evaluates the instruction currently in ID against the older instructions in flight.
// - Results are registered so they line up with that instruction when it enters EX next cycle.

---
 rtl/hazard_ctrl_pkg.sv | 21 ++
 rtl/hazard_ctrl_fwd_sel.sv | 41 ++++
 rtl/hazard_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the EX-stage hazard controller.
//   - Forwarding select encodings driven onto the ALU operand muxes.
//   - Hazard FSM state type.
// No ports (package).
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    // Operand source selects for the ALU input muxes.
    localparam logic [1:0] FWD_RF    = 2'b00;  // register file value
    localparam logic [1:0] FWD_EXMEM = 2'b10;  // EX/MEM ALU result (younger producer)
    localparam logic [1:0] FWD_MEMWB = 2'b01;  // write-back feedback (older producer)

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// -----------------------------------------------------------------------------
// fwd_sel
// Combinational forwarding select for one source operand.
// Compares a source register address against the two in-flight producers and
// returns the mux select. The younger producer (ID/EX) wins over the older one
// (EX/MEM). Register 0 never forwards.
// Ports:
//   i_src      in  AW  source register address of the instruction in ID
//   i_ex_dst   in  AW  destination of the ID/EX instruction
//   i_ex_we    in  1   ID/EX producer is eligible (writes and is not a pending load)
//   i_mem_dst  in  AW  destination of the EX/MEM instruction
//   i_mem_we   in  1   EX/MEM writes a register
//   o_sel      out 2   FWD_RF / FWD_EXMEM / FWD_MEMWB
// -----------------------------------------------------------------------------
module fwd_sel
    import hazard_ctrl_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] i_src,
    input  logic [AW-1:0] i_ex_dst,
    input  logic          i_ex_we,
    input  logic [AW-1:0] i_mem_dst,
    input  logic          i_mem_we,
    output logic [1:0]    o_sel
);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        o_sel = FWD_RF;
        if (i_src != '0) begin
            if (i_ex_we && (i_ex_dst == i_src)) begin
                o_sel = FWD_EXMEM;
            end else if (i_mem_we && (i_mem_dst == i_src)) begin
                o_sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// EX-stage hazard sequencer. Evaluates the instruction in ID against the older
// instructions in ID/EX and EX/MEM and produces registered forwarding selects,
// a one-cycle load-use stall and a multi-cycle flush after a taken branch/jump.
// Results are registered so they line up with the ID instruction once it
// reaches EX.
//
// Parameters:
//   FLUSH_CYCLES  cycles Flush is held after a taken branch/jump (1..7)
//   AW            register address width
// Ports:
//   CLK, RST (synchronous, active-low)
//   IfId_AddrRs/Rt                      sources of the instruction in ID
//   IdEx_RegDst/AddrRt/AddrRd           ID/EX destination selection
//   IdEx_RegWrite/MemRead               ID/EX write enable / load flag
//   ExMem_AddrRdRt/RegWrite             EX/MEM destination and write enable
//   ExMem_Branch/ZeroFlag/Jump          control transfer resolved in EX/MEM
//   FwdRs/FwdRt                         registered operand selects
//   Flush, PC_Stall, IfId_Stall         Moore outputs of the hazard FSM
// Configuration:
//   HAZ_PERF_CNT_EN  adds Stall_Cnt[31:0] and Flush_Cnt[31:0], counting
//                    entries into the stall and flush states (wrapping).
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 3,
    parameter int AW           = 5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] IfId_AddrRs,
    input  logic [AW-1:0] IfId_AddrRt,
    input  logic          IdEx_RegDst,
    input  logic [AW-1:0] IdEx_AddrRt,
    input  logic [AW-1:0] IdEx_AddrRd,
    input  logic          IdEx_RegWrite,
    input  logic          IdEx_MemRead,
    input  logic [AW-1:0] ExMem_AddrRdRt,
    input  logic          ExMem_RegWrite,
    input  logic          ExMem_Branch,
    input  logic          ExMem_ZeroFlag,
    input  logic          ExMem_Jump,
    output logic [1:0]    FwdRs,
    output logic [1:0]    FwdRt,
    output logic          Flush,
    output logic          PC_Stall,
    output logic          IfId_Stall
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]   Stall_Cnt,
    output logic [31:0]   Flush_Cnt
`endif
);

    // Counter reload: the flush state is held for FLUSH_CYCLES cycles, counting
    // down to 0 inclusive.
    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [2:0]    r_cnt;
    logic [2:0]    w_next_cnt;
    logic [1:0]    r_fwd_rs;
    logic [1:0]    r_fwd_rt;

    logic [AW-1:0] w_dst_e;
    logic          w_ldhaz;
    logic          w_take;
    logic          w_ex_we;
    logic          w_hold_fwd;
    logic [1:0]    w_sel_rs;
    logic [1:0]    w_sel_rt;

    // ---------------------------------------------------------------- hazards
    assign w_dst_e = IdEx_RegDst ? IdEx_AddrRd : IdEx_AddrRt;

    assign w_ldhaz = IdEx_MemRead && IdEx_RegWrite && (w_dst_e != '0) &&
                     ((w_dst_e == IfId_AddrRs) || (w_dst_e == IfId_AddrRt));

    assign w_take  = ExMem_Jump || (ExMem_Branch && ExMem_ZeroFlag);

    // A load's result is not yet available in EX, so it cannot be forwarded
    // from the younger slot; the stall resolves it instead.
    assign w_ex_we = IdEx_RegWrite && !w_ldhaz;

    // ------------------------------------------------------------- forwarding
    fwd_sel #(.AW(AW)) u_fwd_rs (
        .i_src     (IfId_AddrRs),
        .i_ex_dst  (w_dst_e),
        .i_ex_we   (w_ex_we),
        .i_mem_dst (ExMem_AddrRdRt),
        .i_mem_we  (ExMem_RegWrite),
        .o_sel     (w_sel_rs)
    );

    fwd_sel #(.AW(AW)) u_fwd_rt (
        .i_src     (IfId_AddrRt),
        .i_ex_dst  (w_dst_e),
        .i_ex_we   (w_ex_we),
        .i_mem_dst (ExMem_AddrRdRt),
        .i_mem_we  (ExMem_RegWrite),
        .o_sel     (w_sel_rt)
    );

    // ------------------------------------------------------------------- FSM
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        Flush        = 1'b0;
        PC_Stall     = 1'b0;
        IfId_Stall   = 1'b0;
        unique case (r_state)
            S_RUN: begin
                // A taken transfer squashes the ID instruction, so it beats
                // any load-use stall raised in the same cycle.
                if (w_take) begin
                    w_next_state = S_FLUSH;
                    w_next_cnt   = FLUSH_LAST;
                end else if (w_ldhaz) begin
                    w_next_state = S_STALL;
                end
            end
            S_STALL: begin
                PC_Stall   = 1'b1;
                IfId_Stall = 1'b1;
                // The load has moved on after one bubble; no re-check here.
                if (w_take) begin
                    w_next_state = S_FLUSH;
                    w_next_cnt   = FLUSH_LAST;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_FLUSH: begin
                Flush = 1'b1;
                // Anything seen while flushing is wrong-path and is ignored.
                if (r_cnt == 3'd0) begin
                    w_next_state = S_RUN;
                end else begin
                    w_next_cnt = r_cnt - 3'd1;
                end
            end
            default: begin
                w_next_state = S_RUN;
                w_next_cnt   = 3'd0;
            end
        endcase
    end

    // Forwarding is meaningless for an instruction about to be stalled or
    // squashed, so it is cleared in those cases.
    assign w_hold_fwd = (w_next_state != S_RUN);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state  <= S_RUN;
            r_cnt    <= 3'd0;
            r_fwd_rs <= FWD_RF;
            r_fwd_rt <= FWD_RF;
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= w_next_cnt;
            r_fwd_rs <= w_hold_fwd ? FWD_RF : w_sel_rs;
            r_fwd_rt <= w_hold_fwd ? FWD_RF : w_sel_rt;
        end
    end

    assign FwdRs = r_fwd_rs;
    assign FwdRt = r_fwd_rt;

`ifdef HAZ_PERF_CNT_EN
    // ---------------------------------------------------- performance counters
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if ((w_next_state == S_STALL) && (r_state != S_STALL)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if ((w_next_state == S_FLUSH) && (r_state != S_FLUSH)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign Stall_Cnt = r_stall_cnt;
    assign Flush_Cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl. A cycle-level model tracks the
// remaining flush cycles and the pending stall and is compared against the DUT
// on every falling edge; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int FLUSH_CYCLES = 3;
    localparam int AW           = 5;

    logic          CLK;
    logic          RST;
    logic [AW-1:0] IfId_AddrRs;
    logic [AW-1:0] IfId_AddrRt;
    logic          IdEx_RegDst;
    logic [AW-1:0] IdEx_AddrRt;
    logic [AW-1:0] IdEx_AddrRd;
    logic          IdEx_RegWrite;
    logic          IdEx_MemRead;
    logic [AW-1:0] ExMem_AddrRdRt;
    logic          ExMem_RegWrite;
    logic          ExMem_Branch;
    logic          ExMem_ZeroFlag;
    logic          ExMem_Jump;
    logic [1:0]    FwdRs;
    logic [1:0]    FwdRt;
    logic          Flush;
    logic          PC_Stall;
    logic          IfId_Stall;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]   Stall_Cnt;
    logic [31:0]   Flush_Cnt;
`endif

    hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .AW(AW)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .IfId_AddrRs    (IfId_AddrRs),
        .IfId_AddrRt    (IfId_AddrRt),
        .IdEx_RegDst    (IdEx_RegDst),
        .IdEx_AddrRt    (IdEx_AddrRt),
        .IdEx_AddrRd    (IdEx_AddrRd),
        .IdEx_RegWrite  (IdEx_RegWrite),
        .IdEx_MemRead   (IdEx_MemRead),
        .ExMem_AddrRdRt (ExMem_AddrRdRt),
        .ExMem_RegWrite (ExMem_RegWrite),
        .ExMem_Branch   (ExMem_Branch),
        .ExMem_ZeroFlag (ExMem_ZeroFlag),
        .ExMem_Jump     (ExMem_Jump),
        .FwdRs          (FwdRs),
        .FwdRt          (FwdRt),
        .Flush          (Flush),
        .PC_Stall       (PC_Stall),
        .IfId_Stall     (IfId_Stall)
`ifdef HAZ_PERF_CNT_EN
        ,
        .Stall_Cnt      (Stall_Cnt),
        .Flush_Cnt      (Flush_Cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    int          m_flush_rem = 0;   // flush cycles still to be shown
    bit          m_stall     = 0;   // stall shown this cycle
    logic [1:0]  m_fwd_rs    = 2'b00;
    logic [1:0]  m_fwd_rt    = 2'b00;
    int unsigned m_stall_cnt = 0;
    int unsigned m_flush_cnt = 0;
    bit          m_live      = 0;

    function automatic logic [AW-1:0] dest_e();
        return IdEx_RegDst ? IdEx_AddrRd : IdEx_AddrRt;
    endfunction

    function automatic bit load_use();
        logic [AW-1:0] d = dest_e();
        return IdEx_MemRead && IdEx_RegWrite && d != 0 &&
               (d == IfId_AddrRs || d == IfId_AddrRt);
    endfunction

    function automatic logic [1:0] fwd_rule(input logic [AW-1:0] s);
        if (s == 0) return 2'b00;
        if (IdEx_RegWrite && dest_e() == s && !load_use()) return 2'b10;
        if (ExMem_RegWrite && ExMem_AddrRdRt == s) return 2'b01;
        return 2'b00;
    endfunction

    always @(posedge CLK) begin
        int nr;
        bit ns;
        bit take;
        m_live = 1;
        if (!RST) begin
            m_flush_rem = 0;
            m_stall     = 0;
            m_fwd_rs    = 2'b00;
            m_fwd_rt    = 2'b00;
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
            take = ExMem_Jump || (ExMem_Branch && ExMem_ZeroFlag);
            nr   = 0;
            ns   = 0;
            if (m_flush_rem > 0)  nr = m_flush_rem - 1;
            else if (m_stall)     nr = take ? FLUSH_CYCLES : 0;
            else if (take)        nr = FLUSH_CYCLES;
            else if (load_use())  ns = 1;
            if (ns) m_stall_cnt++;
            if (nr > 0 && m_flush_rem == 0) m_flush_cnt++;
            if (nr > 0 || ns) begin
                m_fwd_rs = 2'b00;
                m_fwd_rt = 2'b00;
            end else begin
                m_fwd_rs = fwd_rule(IfId_AddrRs);
                m_fwd_rt = fwd_rule(IfId_AddrRt);
            end
            m_flush_rem = nr;
            m_stall     = ns;
        end
    end

    // Compare process: outputs are stable away from the rising edge.
    always @(negedge CLK) begin
        if (m_live) begin
            check("model_flush",  {31'd0, Flush},      {31'd0, m_flush_rem > 0});
            check("model_pcstl",  {31'd0, PC_Stall},   {31'd0, m_stall});
            check("model_ifstl",  {31'd0, IfId_Stall}, {31'd0, m_stall});
            check("model_fwdrs",  {30'd0, FwdRs},      {30'd0, m_fwd_rs});
            check("model_fwdrt",  {30'd0, FwdRt},      {30'd0, m_fwd_rt});
            check("model_excl",   {31'd0, Flush && PC_Stall}, 32'd0);
`ifdef HAZ_PERF_CNT_EN
            check("model_stlcnt", Stall_Cnt, m_stall_cnt);
            check("model_flscnt", Flush_Cnt, m_flush_cnt);
`endif
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic clear_inputs();
        IfId_AddrRs    = '0;
        IfId_AddrRt    = '0;
        IdEx_RegDst    = 1'b0;
        IdEx_AddrRt    = '0;
        IdEx_AddrRd    = '0;
        IdEx_RegWrite  = 1'b0;
        IdEx_MemRead   = 1'b0;
        ExMem_AddrRdRt = '0;
        ExMem_RegWrite = 1'b0;
        ExMem_Branch   = 1'b0;
        ExMem_ZeroFlag = 1'b0;
        ExMem_Jump     = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        clear_inputs();
        RST = 1'b0;

        // Reset held for two cycles with a taken branch present.
        ExMem_Branch   = 1'b1;
        ExMem_ZeroFlag = 1'b1;
        tick();
        tick();
        check("rst_flush", {31'd0, Flush},    32'd0);
        check("rst_pcstl", {31'd0, PC_Stall}, 32'd0);
        check("rst_fwdrs", {30'd0, FwdRs},    32'd0);
        check("rst_fwdrt", {30'd0, FwdRt},    32'd0);
        // Release with the branch still present: reaction comes at the next edge.
        RST = 1'b1;
        #1;
        check("rel_noflush", {31'd0, Flush}, 32'd0);
        tick();
        check("rel_flush", {31'd0, Flush}, 32'd1);
        clear_inputs();
        repeat (3) tick();
        check("rel_done", {31'd0, Flush}, 32'd0);

        // EX forward on Rs.
        IdEx_RegWrite = 1'b1;
        IdEx_RegDst   = 1'b1;
        IdEx_AddrRd   = 5'd9;
        IfId_AddrRs   = 5'd9;
        IfId_AddrRt   = 5'd4;
        tick();
        check("exfwd_rs", {30'd0, FwdRs}, 32'h2);
        check("exfwd_rt", {30'd0, FwdRt}, 32'h0);

        // Dual match on Rt: younger producer wins, then older when younger drops.
        clear_inputs();
        IdEx_RegWrite  = 1'b1;
        IdEx_RegDst    = 1'b0;
        IdEx_AddrRt    = 5'd3;
        ExMem_RegWrite = 1'b1;
        ExMem_AddrRdRt = 5'd3;
        IfId_AddrRt    = 5'd3;
        IfId_AddrRs    = 5'd1;
        tick();
        check("dual_rt_ex", {30'd0, FwdRt}, 32'h2);
        IdEx_RegWrite = 1'b0;
        tick();
        check("dual_rt_mem", {30'd0, FwdRt}, 32'h1);

        // Load-use: one stall cycle, then forward from the older slot.
        clear_inputs();
        IdEx_RegWrite = 1'b1;
        IdEx_MemRead  = 1'b1;
        IdEx_RegDst   = 1'b1;
        IdEx_AddrRd   = 5'd8;
        IfId_AddrRt   = 5'd8;
        tick();
        check("lu_pcstl", {31'd0, PC_Stall},   32'd1);
        check("lu_ifstl", {31'd0, IfId_Stall}, 32'd1);
        check("lu_fwdrt", {30'd0, FwdRt},      32'h0);
        IdEx_RegWrite  = 1'b0;
        IdEx_MemRead   = 1'b0;
        ExMem_RegWrite = 1'b1;
        ExMem_AddrRdRt = 5'd8;
        tick();
        check("lu_release", {31'd0, PC_Stall}, 32'd0);
        check("lu_fwd_mem", {30'd0, FwdRt},    32'h1);

        // Branch: three flush cycles, forwarding suppressed, retake ignored.
        clear_inputs();
        ExMem_Branch   = 1'b1;
        ExMem_ZeroFlag = 1'b1;
        IdEx_RegWrite  = 1'b1;
        IdEx_RegDst    = 1'b1;
        IdEx_AddrRd    = 5'd9;
        IfId_AddrRs    = 5'd9;
        tick();
        check("br_flush1", {31'd0, Flush}, 32'd1);
        check("br_fwdrs",  {30'd0, FwdRs}, 32'h0);
        tick();
        check("br_flush2", {31'd0, Flush}, 32'd1);
        tick();
        check("br_flush3", {31'd0, Flush}, 32'd1);
        ExMem_Branch   = 1'b0;
        ExMem_ZeroFlag = 1'b0;
        tick();
        check("br_end",     {31'd0, Flush}, 32'd0);
        check("br_end_fwd", {30'd0, FwdRs}, 32'h2);

        // Take and load-use together: flush only.
        clear_inputs();
        ExMem_Jump    = 1'b1;
        IdEx_RegWrite = 1'b1;
        IdEx_MemRead  = 1'b1;
        IdEx_RegDst   = 1'b1;
        IdEx_AddrRd   = 5'd8;
        IfId_AddrRt   = 5'd8;
        tick();
        check("cf_flush", {31'd0, Flush},    32'd1);
        check("cf_nostl", {31'd0, PC_Stall}, 32'd0);
        clear_inputs();
        repeat (3) tick();
        check("cf_end",   {31'd0, Flush},    32'd0);
        check("cf_end_s", {31'd0, PC_Stall}, 32'd0);

        // Register 0 never forwards nor stalls.
        IdEx_RegWrite  = 1'b1;
        IdEx_MemRead   = 1'b1;
        IdEx_RegDst    = 1'b1;
        ExMem_RegWrite = 1'b1;
        tick();
        check("z_pcstl", {31'd0, PC_Stall}, 32'd0);
        check("z_fwdrs", {30'd0, FwdRs},    32'h0);
        check("z_fwdrt", {30'd0, FwdRt},    32'h0);

        // Stall followed by a take during the stall.
        clear_inputs();
        IdEx_RegWrite = 1'b1;
        IdEx_MemRead  = 1'b1;
        IdEx_AddrRt   = 5'd5;
        IfId_AddrRs   = 5'd5;
        tick();
        check("st_pcstl", {31'd0, PC_Stall}, 32'd1);
        clear_inputs();
        ExMem_Jump = 1'b1;
        tick();
        check("st_flush", {31'd0, Flush},    32'd1);
        check("st_nostl", {31'd0, PC_Stall}, 32'd0);
        clear_inputs();
        repeat (3) tick();
        check("st_end", {31'd0, Flush}, 32'd0);

        // Reset in the middle of a flush aborts it.
        ExMem_Jump = 1'b1;
        tick();
        check("rmf_flush", {31'd0, Flush}, 32'd1);
        ExMem_Jump = 1'b0;
        RST        = 1'b0;
        tick();
        check("rmf_abort", {31'd0, Flush}, 32'd0);
        RST = 1'b1;
        tick();

        // Mixed traffic against the model, small address space for collisions.
        for (int i = 0; i < 400; i++) begin
            IfId_AddrRs    = AW'($urandom_range(0, 3));
            IfId_AddrRt    = AW'($urandom_range(0, 3));
            IdEx_RegDst    = 1'($urandom_range(0, 1));
            IdEx_AddrRt    = AW'($urandom_range(0, 3));
            IdEx_AddrRd    = AW'($urandom_range(0, 3));
            IdEx_RegWrite  = 1'($urandom_range(0, 1));
            IdEx_MemRead   = 1'($urandom_range(0, 1));
            ExMem_AddrRdRt = AW'($urandom_range(0, 3));
            ExMem_RegWrite = 1'($urandom_range(0, 1));
            ExMem_Branch   = ($urandom_range(0, 7) == 0);
            ExMem_ZeroFlag = 1'($urandom_range(0, 1));
            ExMem_Jump     = ($urandom_range(0, 15) == 0);
            RST            = ($urandom_range(0, 99) != 0);
            tick();
        end

        clear_inputs();
        RST = 1'b1;
        repeat (2) tick();
        @(negedge CLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
